// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel rate.
package vga_timing_pkg;

    localparam int unsigned POS_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, sync/blanking/coordinates/strobes out.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic pix_ce;
    logic hsync;
    logic vsync;
    logic display_on;
    pos_t hpos;
    pos_t vpos;
    logic line_start;
    logic frame_start;
    logic vblank_tick;

    modport master (
        input  pix_ce,
        output hsync, vsync, display_on, hpos, vpos,
        output line_start, frame_start, vblank_tick
    );

    modport slave (
        output pix_ce,
        input  hsync, vsync, display_on, hpos, vpos,
        input  line_start, frame_start, vblank_tick
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus an ACTIVE/FRONT/SYNC/BACK phase FSM.
// Next-state phase is exported so the top can register sync/blanking aligned with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int unsigned FRONT_LEN  = H_FRONT_DEF,
    parameter int unsigned SYNC_LEN   = H_SYNC_DEF,
    parameter int unsigned BACK_LEN   = H_BACK_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step_i,
    output pos_t   pos_o,
    output phase_e phase_d_o,
    output logic   wrap_o,
    output logic   sync_active_o
);

    localparam int unsigned TOTAL    = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam pos_t        LAST_POS = pos_t'(TOTAL - 1);

    if (TOTAL > 1024 || ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1) begin : g_bad_params
        $error("vga_axis_counter: phase lengths must be >=1 and sum to <=1024");
    end

    function automatic pos_t phase_len(input phase_e p);
        unique case (p)
            PH_ACTIVE: phase_len = pos_t'(ACTIVE_LEN);
            PH_FRONT:  phase_len = pos_t'(FRONT_LEN);
            PH_SYNC:   phase_len = pos_t'(SYNC_LEN);
            PH_BACK:   phase_len = pos_t'(BACK_LEN);
        endcase
    endfunction

    pos_t   pos_q, pos_d;
    pos_t   cnt_q, cnt_d;
    phase_e phase_q, phase_d;
    logic   phase_end;
    logic   wrap;

    assign phase_end = (cnt_q == phase_len(phase_q) - pos_t'(1));
    assign wrap      = (phase_q == PH_BACK) && phase_end;

    always_comb begin
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (step_i) begin
            pos_d = wrap ? '0 : pos_q + pos_t'(1);
            if (phase_end) begin
                cnt_d = '0;
                unique case (phase_q)
                    PH_ACTIVE: phase_d = PH_FRONT;
                    PH_FRONT:  phase_d = PH_SYNC;
                    PH_SYNC:   phase_d = PH_BACK;
                    PH_BACK:   phase_d = PH_ACTIVE;
                endcase
            end else begin
                cnt_d = cnt_q + pos_t'(1);
            end
        end
    end

    // Reset parks the axis on its final position so the first step lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= LAST_POS;
            cnt_q   <= pos_t'(BACK_LEN - 1);
            phase_q <= PH_BACK;
        end else begin
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign pos_o         = pos_q;
    assign phase_d_o     = phase_d;
    assign wrap_o        = wrap;
    assign sync_active_o = (phase_d == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered sync, blanking, coordinates and
// single-cycle line/frame/vblank strobes, advancing only on pix_ce.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    vga_timing_gen_if.master  vga
);

    pos_t   h_pos, v_pos;
    phase_e h_phase_d, v_phase_d;
    logic   h_wrap, v_wrap;
    logic   h_sync_d, v_sync_d;
    logic   v_step;

    assign v_step = vga.pix_ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .step_i(vga.pix_ce),
        .pos_o(h_pos), .phase_d_o(h_phase_d), .wrap_o(h_wrap), .sync_active_o(h_sync_d)
    );

    vga_axis_counter #(
        .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .step_i(v_step),
        .pos_o(v_pos), .phase_d_o(v_phase_d), .wrap_o(v_wrap), .sync_active_o(v_sync_d)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic display_on_q, display_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
    logic vblank_tick_q, vblank_tick_d;

    // Derived from next-state phases so these registers update on the same edge as the counters.
    always_comb begin
        hsync_d       = h_sync_d ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = v_sync_d ? VSYNC_POL : ~VSYNC_POL;
        display_on_d  = (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
        line_start_d  = v_step;
        frame_start_d = v_step && v_wrap;
        vblank_tick_d = v_step && (v_pos == pos_t'(V_ACTIVE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_tick_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_tick_q <= vblank_tick_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.display_on  = display_on_q;
    assign vga.hpos        = h_pos;
    assign vga.vpos        = v_pos;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank_tick = vblank_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full 640x480 instance for reset and horizontal timing,
// and a scaled 16x12 instance (active-high hsync) for vertical, frame and stall behaviour.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_ce;

    always #5 clk = ~clk;

    vga_timing_gen_if vf ();
    vga_timing_gen_if vsm ();

    assign vf.pix_ce  = pix_ce;
    assign vsm.pix_ce = pix_ce;

    vga_timing_gen u_full (
        .clk(clk), .rst_n(rst_n), .vga(vf)
    );

    // Small raster: H 8/2/3/3 (total 16), V 6/2/2/2 (total 12); hsync active-high.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .vga(vsm)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            pix_ce = 1'b1;
            @(posedge clk);
            #1;
        end
        pix_ce = 1'b0;
    endtask

    task automatic check_small(input string tag, input int h, input int v, input bit hs,
                               input bit vs, input bit de, input bit ls, input bit fs, input bit vb);
        check({tag, "_hpos"},  32'(vsm.hpos),        32'(h));
        check({tag, "_vpos"},  32'(vsm.vpos),        32'(v));
        check({tag, "_hsync"}, 32'(vsm.hsync),       32'(hs));
        check({tag, "_vsync"}, 32'(vsm.vsync),       32'(vs));
        check({tag, "_de"},    32'(vsm.display_on),  32'(de));
        check({tag, "_ls"},    32'(vsm.line_start),  32'(ls));
        check({tag, "_fs"},    32'(vsm.frame_start), 32'(fs));
        check({tag, "_vb"},    32'(vsm.vblank_tick), 32'(vb));
    endtask

    task automatic check_full(input string tag, input int h, input int v, input bit hs,
                              input bit vs, input bit de, input bit ls, input bit fs, input bit vb);
        check({tag, "_hpos"},  32'(vf.hpos),        32'(h));
        check({tag, "_vpos"},  32'(vf.vpos),        32'(v));
        check({tag, "_hsync"}, 32'(vf.hsync),       32'(hs));
        check({tag, "_vsync"}, 32'(vf.vsync),       32'(vs));
        check({tag, "_de"},    32'(vf.display_on),  32'(de));
        check({tag, "_ls"},    32'(vf.line_start),  32'(ls));
        check({tag, "_fs"},    32'(vf.frame_start), 32'(fs));
        check({tag, "_vb"},    32'(vf.vblank_tick), 32'(vb));
    endtask

    // Runs the small raster for one full frame (frame_start to frame_start) and tallies it.
    task automatic measure(input bit div2, output int period, output int lines, output int vbl,
                           output int de_cyc, output int frz);
        int   nfs;
        int   start;
        int   ph;
        int   pv;
        logic prev_ce;
        nfs = 0; start = 0; period = -1; lines = 0; vbl = 0; de_cyc = 0; frz = 0;
        ph = int'(vsm.hpos);
        pv = int'(vsm.vpos);
        pix_ce = 1'b1;
        for (int i = 0; i < 2000 && nfs < 2; i++) begin
            prev_ce = pix_ce;
            @(posedge clk);
            #1;
            if (!prev_ce && (int'(vsm.hpos) != ph || int'(vsm.vpos) != pv || vsm.line_start
                             || vsm.frame_start || vsm.vblank_tick))
                frz++;
            if (vsm.frame_start) begin
                nfs++;
                if (nfs == 2) period = i - start;
                else start = i;
            end
            if (nfs == 1) begin
                lines  += int'(vsm.line_start);
                vbl    += int'(vsm.vblank_tick);
                de_cyc += int'(vsm.display_on);
            end
            ph = int'(vsm.hpos);
            pv = int'(vsm.vpos);
            if (div2) pix_ce = ~pix_ce;
        end
        pix_ce = 1'b0;
    endtask

    typedef struct {
        int n;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        bit vb;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int period, lines, vbl, de_cyc, frz, cnt;

        //            n    h   v  hs vs de ls fs vb   (small raster, cumulative pix_ce steps)
        tbl[0]  = '{  1,   0,  0, 0, 1, 1, 1, 1, 0};
        tbl[1]  = '{  1,   1,  0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{  6,   7,  0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{  1,   8,  0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{  2,  10,  0, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{  2,  12,  0, 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{  1,  13,  0, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{  2,  15,  0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{  1,   0,  1, 0, 1, 1, 1, 0, 0};
        tbl[9]  = '{ 79,  15,  5, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{  1,   0,  6, 0, 1, 0, 1, 0, 1};
        tbl[11] = '{  1,   1,  6, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{ 31,   0,  8, 0, 0, 0, 1, 0, 0};
        tbl[13] = '{ 31,  15,  9, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{  1,   0, 10, 0, 1, 0, 1, 0, 0};
        tbl[15] = '{ 31,  15, 11, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{  1,   0,  0, 0, 1, 1, 1, 1, 0};
        tbl[17] = '{156,  12,  9, 1, 0, 0, 0, 0, 0};

        pix_ce = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_full("rst_full", 799, 524, 1, 1, 0, 0, 0, 0);
        check_small("rst_small", 15, 11, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_full("idle_full", 799, 524, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].n);
            check_small($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
                        tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].vb);
        end

        measure(1'b0, period, lines, vbl, de_cyc, frz);
        check("full_rate_period", 32'(period), 32'd192);
        check("full_rate_lines",  32'(lines),  32'd12);
        check("full_rate_vblank", 32'(vbl),    32'd1);
        check("full_rate_de",     32'(de_cyc), 32'd48);

        measure(1'b1, period, lines, vbl, de_cyc, frz);
        check("div2_period", 32'(period), 32'd384);
        check("div2_lines",  32'(lines),  32'd12);
        check("div2_vblank", 32'(vbl),    32'd1);
        check("div2_de",     32'(de_cyc), 32'd96);
        check("div2_frozen", 32'(frz),    32'd0);

        // Async reset mid-line: applied between clock edges and checked before the next one.
        for (int i = 0; i < 400; i++) begin
            if (vsm.hpos == pos_t'(5) && vsm.vpos == pos_t'(3)) break;
            step(1);
        end
        check("reach_5_3", 32'({vsm.vpos, vsm.hpos}), 32'({10'd3, 10'd5}));
        #2;
        rst_n = 1'b0;
        #1;
        check_small("async_small", 15, 11, 0, 1, 0, 0, 0, 0);
        check_full("async_full", 799, 524, 1, 1, 0, 0, 0, 0);
        pix_ce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_small("inrst_small", 15, 11, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        check_small("restart_small", 0, 0, 0, 1, 1, 1, 1, 0);
        check_full("restart_full", 0, 0, 1, 1, 1, 1, 1, 0);
        @(posedge clk);
        #1;
        check_full("stall_full", 0, 0, 1, 1, 1, 0, 0, 0);

        step(639);
        check_full("h639", 639, 0, 1, 1, 1, 0, 0, 0);
        step(1);
        check_full("h640", 640, 0, 1, 1, 0, 0, 0, 0);
        step(15);
        check_full("h655", 655, 0, 1, 1, 0, 0, 0, 0);
        step(1);
        check_full("h656", 656, 0, 0, 1, 0, 0, 0, 0);
        step(95);
        check_full("h751", 751, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        check_full("h752", 752, 0, 1, 1, 0, 0, 0, 0);
        step(47);
        check_full("h799", 799, 0, 1, 1, 0, 0, 0, 0);
        step(1);
        check_full("line1", 0, 1, 1, 1, 1, 1, 0, 0);

        cnt = 0;
        pix_ce = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (vf.line_start) break;
        end
        pix_ce = 1'b0;
        check("line_period", 32'(cnt), 32'd800);
        check("line2_vpos",  32'(vf.vpos), 32'd2);
        check("line2_hpos",  32'(vf.hpos), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
